// File: rtl/cas_tx_sequencer.sv
// Cassette block transmitter: motor spin-up, leader tone, framed bytes (start/8 data LSB first/stop), trailer.
// Define CAS_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module cas_tx_sequencer #(
  parameter int SPINUP_BITS  = 512,
  parameter int LEADER_BITS  = 6000,
  parameter int TRAILER_BITS = 1200
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       bit_tick,
  input  logic       start,
  input  logic       abort,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       motor_on,
  output logic       tx_enable,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    SPINUP  = 4'd1,
    LEADER  = 4'd2,
    START   = 4'd3,
    DATA    = 4'd4,
    PARITY  = 4'd5,
    STOP    = 4'd6,
    GAP     = 4'd7,
    TRAILER = 4'd8
  } state_t;

  localparam logic [15:0] SPINUP_LAST  = 16'(SPINUP_BITS - 1);
  localparam logic [15:0] LEADER_LAST  = 16'(LEADER_BITS - 1);
  localparam logic [15:0] TRAILER_LAST = 16'(TRAILER_BITS - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [7:0]  hold_data;
  logic        hold_full;
  logic        hold_last;
  logic [7:0]  shift;
  logic        shift_last;

`ifdef CAS_TX_PARITY_EN
  logic        par_bit;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  assign busy       = (state != IDLE);
  assign byte_ready = busy && !hold_full;

  // Sequencer FSM: bit counter, holding register and shift register.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      hold_data  <= 8'd0;
      hold_full  <= 1'b0;
      hold_last  <= 1'b0;
      shift      <= 8'd0;
      shift_last <= 1'b0;
      done       <= 1'b0;
`ifdef CAS_TX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (byte_valid && byte_ready) begin
        hold_data <= byte_data;
        hold_last <= byte_last;
        hold_full <= 1'b1;
      end
      if (state != IDLE && abort) begin
        // Abort wins over everything, including a byte accepted this same clk.
        state      <= IDLE;
        cnt        <= 16'd0;
        hold_full  <= 1'b0;
        shift_last <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state <= SPINUP;
              cnt   <= 16'd0;
            end
          end
          SPINUP: begin
            if (bit_tick) begin
              if (cnt == SPINUP_LAST) begin
                state <= LEADER;
                cnt   <= 16'd0;
              end else begin
                cnt <= cnt + 16'd1;
              end
            end
          end
          LEADER: begin
            if (bit_tick) begin
              if (cnt != LEADER_LAST) begin
                cnt <= cnt + 16'd1;
              end else if (hold_full) begin
                shift      <= hold_data;
                shift_last <= hold_last;
                hold_full  <= 1'b0;
                state      <= START;
`ifdef CAS_TX_PARITY_EN
                par_bit    <= even_parity(hold_data);
`endif
              end else begin
                state <= GAP;
              end
            end
          end
          START: begin
            if (bit_tick) begin
              state <= DATA;
              cnt   <= 16'd0;
            end
          end
          DATA: begin
            if (bit_tick) begin
              shift <= {1'b0, shift[7:1]};
              if (cnt == 16'd7) begin
`ifdef CAS_TX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                cnt <= cnt + 16'd1;
              end
            end
          end
`ifdef CAS_TX_PARITY_EN
          PARITY: begin
            if (bit_tick) begin
              state <= STOP;
            end
          end
`endif
          STOP, GAP: begin
            if (bit_tick) begin
              if (state == STOP && shift_last) begin
                state <= TRAILER;
                cnt   <= 16'd0;
              end else if (hold_full) begin
                shift      <= hold_data;
                shift_last <= hold_last;
                hold_full  <= 1'b0;
                state      <= START;
`ifdef CAS_TX_PARITY_EN
                par_bit    <= even_parity(hold_data);
`endif
              end else begin
                state <= GAP;
              end
            end
          end
          TRAILER: begin
            if (bit_tick) begin
              if (cnt == TRAILER_LAST) begin
                state <= IDLE;
                cnt   <= 16'd0;
                done  <= 1'b1;
              end else begin
                cnt <= cnt + 16'd1;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= 16'd0;
          end
        endcase
      end
    end
  end

  // Modulator and relay drives follow the state one clk later.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      motor_on  <= 1'b0;
      tx_enable <= 1'b0;
      txd       <= 1'b1;
    end else begin
      motor_on  <= (state != IDLE);
      tx_enable <= (state != IDLE) && (state != SPINUP);
      case (state)
        START:   txd <= 1'b0;
        DATA:    txd <= shift[0];
`ifdef CAS_TX_PARITY_EN
        PARITY:  txd <= par_bit;
`endif
        default: txd <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_cas_tx_sequencer.sv
// Self-checking bench for cas_tx_sequencer: directed scenarios plus random blocks against a
// tick-level arithmetic model of the expected serial stream.
module tb_cas_tx_sequencer;

  localparam int SP = 2;
  localparam int LD = 4;
  localparam int TR = 3;
`ifdef CAS_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic       bit_tick = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_last = 1'b0;
  logic       byte_ready, motor_on, tx_enable, txd, busy, done;

  int n_checks = 0;
  int n_pass = 0;
  int phase = 0;
  int tick_no = 0;
  bit counting = 1'b0;
  int done_cnt = 0;
  int done_tick = -1;
  logic [2:0] rec_q[$];
  logic       exp_q[$];
  logic [7:0] bq[8];
  int         oq[8];
  int         nb;

  cas_tx_sequencer #(.SPINUP_BITS(SP), .LEADER_BITS(LD), .TRAILER_BITS(TR)) dut (
    .clk(clk), .nRST(nRST), .bit_tick(bit_tick), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready), .motor_on(motor_on), .tx_enable(tx_enable), .txd(txd),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // bit_tick strobe: one clk in every eight
  initial forever begin
    @(negedge clk);
    phase = (phase + 1) % 8;
    bit_tick = (phase == 7);
  end

  // ticks counted since the start edge of the current block
  initial forever begin
    @(posedge clk);
    if (!counting) tick_no = 0;
    else if (bit_tick) tick_no++;
  end

  // per-tick record of {motor_on, tx_enable, txd} just before each tick, and done pulses
  initial forever begin
    @(negedge clk);
    #1;
    if (!counting) begin
      rec_q.delete();
      done_cnt = 0;
      done_tick = -1;
    end else begin
      if (phase == 7) rec_q.push_back({motor_on, tx_enable, txd});
      if (done) begin
        done_cnt++;
        done_tick = tick_no;
      end
    end
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_early();
    do begin
      @(negedge clk);
      #1;
    end while (phase > 3);
  endtask

  task automatic wait_tick(input int t);
    int c = 0;
    while (tick_no < t && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check_eq("tick_reached", (tick_no >= t) ? 1 : 0, 1);
  endtask

  // Expected txd per tick: idle-high until each byte's load tick, then its frame, then trailer.
  task automatic build_expect();
    int d_prev = 0;
    int a, d;
    exp_q.delete();
    for (int k = 0; k < nb; k++) begin
      if (k == 0) begin
        a = oq[0] + 1;
        d = (a > SP + LD) ? a : SP + LD;
      end else begin
        a = ((oq[k] > d_prev) ? oq[k] : d_prev) + 1;
        d = (a > d_prev + FRAME) ? a : d_prev + FRAME;
      end
      while (exp_q.size() < d) exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) exp_q.push_back(bq[k][b]);
`ifdef CAS_TX_PARITY_EN
      exp_q.push_back(^bq[k]);
`endif
      exp_q.push_back(1'b1);
      d_prev = d;
    end
    for (int t = 0; t < TR; t++) exp_q.push_back(1'b1);
  endtask

  task automatic compare_stream(input int upto);
    for (int i = 0; i < upto; i++) begin
      if (i >= rec_q.size()) begin
        check_eq("rec_len", rec_q.size(), upto);
        break;
      end
      check_eq($sformatf("tick%0d", i + 1), rec_q[i],
               {1'b1, ((i + 1) > SP) ? 1'b1 : 1'b0, exp_q[i]});
    end
  endtask

  task automatic begin_block(input bit hold_start);
    counting = 1'b0;
    repeat (2) @(negedge clk);
    wait_early();
    start = 1'b1;
    @(posedge clk);
    #1;
    counting = 1'b1;
    if (!hold_start) start = 1'b0;
  endtask

  task automatic drive_bytes();
    int c;
    for (int k = 0; k < nb; k++) begin
      wait_tick(oq[k]);
      wait_early();
      byte_valid = 1'b1;
      byte_data = bq[k];
      byte_last = (k == nb - 1);
      c = 0;
      while (!byte_ready && c < 3000) begin
        @(negedge clk);
        c++;
      end
      check_eq("ready_seen", byte_ready, 1);
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      byte_last = 1'b0;
      @(negedge clk);
      check_eq("ready_low_when_full", byte_ready, 0);
    end
  endtask

  task automatic finish_block();
    int c = 0;
    while (done_cnt == 0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check_eq("done_seen", (done_cnt > 0) ? 1 : 0, 1);
    build_expect();
    compare_stream(exp_q.size());
    check_eq("done_tick", done_tick, exp_q.size());
    repeat (2) @(negedge clk);
    check_eq("done_once", done_cnt, 1);
    check_eq("post_busy", busy, 0);
    check_eq("post_motor", motor_on, 0);
    check_eq("post_txen", tx_enable, 0);
    check_eq("post_txd", txd, 1);
    counting = 1'b0;
  endtask

  task automatic run_block();
    begin_block(1'b0);
    fork
      drive_bytes();
      finish_block();
    join
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_motor", motor_on, 0);
    check_eq("rst_txen", tx_enable, 0);
    check_eq("rst_txd", txd, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ready", byte_ready, 0);
    nRST = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("idle_ignores_tick", busy, 0);

    // single byte 0xA5, motor relay lag
    nb = 1; bq[0] = 8'hA5; oq[0] = 0;
    begin_block(1'b0);
    check_eq("busy_after_start", busy, 1);
    check_eq("motor_lag0", motor_on, 0);
    @(posedge clk);
    #1;
    check_eq("motor_lag1", motor_on, 1);
    fork
      drive_bytes();
      finish_block();
    join

    // back-to-back bytes
    nb = 2; bq[0] = 8'h00; bq[1] = 8'hFF; oq[0] = 0; oq[1] = 0;
    run_block();

    // second byte late: GAP ticks then START
    nb = 2; bq[0] = 8'h5A; bq[1] = 8'hC3; oq[0] = 0; oq[1] = SP + LD + FRAME + 20;
    run_block();

    // abort during DATA bit 3 of 0x3C
    nb = 1; bq[0] = 8'h3C; oq[0] = 0;
    begin_block(1'b0);
    drive_bytes();
    wait_tick(SP + LD + 4);
    wait_early();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ready", byte_ready, 0);
    @(negedge clk);
    check_eq("abort_motor", motor_on, 0);
    check_eq("abort_txen", tx_enable, 0);
    check_eq("abort_txd", txd, 1);
    build_expect();
    compare_stream(SP + LD + 4);
    repeat (40) @(negedge clk);
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_idle", busy, 0);
    counting = 1'b0;

    // start held while busy, then reset in LEADER overriding start/abort
    nb = 1; bq[0] = 8'h07; oq[0] = 0;
    begin_block(1'b1);
    drive_bytes();
    wait_tick(3);
    build_expect();
    compare_stream(3);
    wait_early();
    nRST = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1;
    nRST = 1'b1;
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("mrst_motor", motor_on, 0);
    check_eq("mrst_txen", tx_enable, 0);
    check_eq("mrst_txd", txd, 1);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_done", done, 0);
    check_eq("mrst_ready", byte_ready, 0);
    repeat (40) @(negedge clk);
    check_eq("mrst_no_done", done_cnt, 0);
    check_eq("mrst_idle", busy, 0);
    counting = 1'b0;

    // random blocks
    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(1, 4);
      oq[0] = $urandom_range(0, 8);
      bq[0] = 8'($urandom);
      for (int k = 1; k < nb; k++) begin
        bq[k] = 8'($urandom);
        oq[k] = oq[k - 1] + $urandom_range(0, 14);
      end
      run_block();
    end

    // byte 0x07 (odd weight: parity bit 1 when enabled)
    nb = 1; bq[0] = 8'h07; oq[0] = 1;
    run_block();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
